stream_fork_buffer: RTL and testbench
=====================================

# stream_fork_buffer

Parametrised elastic stream buffer with multi-consumer fork, the generic successor to the fixed per-signal offset buffers and hand-wired ready-AND glue in generated kernel tops. It holds NCH aligned 34-bit lanes per entry in a circular store of DEPTH entries. It withholds output until PRIME entries have accumulated, to balance pipeline offsets. It presents the head entry to NCONS independent consumers with per-consumer valid/ready.

## Interface
- DATAW, 34: width of one lane
- NCH, 2: lanes per entry, written and read together
- DEPTH, 23: entries; any value ≥ 2, not required to be a power of two
- PRIME, 22: entries required before first output after reset or after a drain; 0 ≤ PRIME ≤ DEPTH
- NCONS, 2: number of consumers on the output fork
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in  in  NCH*DATAW  input entry; lane k at bits [k*DATAW +: DATAW]
- ivalid  in  1  input entry valid
- ilast  in  1  qualifies the final entry of a stream; sampled with the push
- iready  out  1  buffer accepts an entry this cycle
- out  out  NCH*DATAW  head entry, common to all consumers
- ovalid  out  NCONS  per-consumer head valid
- oready  in  NCONS  per-consumer ready
- olast  out  1  head entry carries ilast
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Push when ivalid & iready: write in/ilast at wptr; wptr wraps DEPTH-1 → 0.
- iready = (count < DEPTH) & rst. It is derived from registered count only, so a pop does not free space in the same cycle.
- Pop advances rptr with the same wrap rule.
- count is incremented on push-only, decremented on pop-only, and unchanged on push+pop.
- State machine:
  - PRIME: ovalid all 0. Go to RUN when count ≥ PRIME. Go to DRAIN when a stored entry has last set. With PRIME=0, PRIME is left whenever count > 0.
  - RUN: head is offered to consumers.
  - DRAIN: head is offered regardless of count. Entered from PRIME or RUN when a pushed entry has ilast. Returns to PRIME in the cycle after the popped entry has olast. Pushes continue during DRAIN.
- Fork, eager (see Configuration):
  - served[i] flag per consumer.
  - ovalid[i] = offering & nonempty & ~served[i].
  - Consumer i handshakes on ovalid[i] & oready[i] and sets served[i].
  - The entry pops when every consumer is served or handshaking this cycle; all served flags clear on pop.
- out and olast are driven combinationally from the store at rptr (show-ahead). They are don't-care while no ovalid bit is set.
- Arithmetic: pointers and count are unsigned and use explicit compare-and-wrap, never modulo.

## Timing
- Reset (rst low, asynchronous):
  - wptr, rptr, count = 0; served = 0; state = PRIME.
  - iready = 0, ovalid = 0, olast = 0, count = 0.
  - iready rises on the first clk edge-free cycle after rst deasserts.
- Latency:
  - An entry pushed at edge N is visible at out after edge N.
  - ovalid asserts after edge N only if this push satisfied the PRIME/DRAIN condition.
  - Minimum latency is 1 cycle with PRIME ≤ 1.
- Full: iready = 0. A simultaneous pop does not reopen iready until the next cycle.
- Empty: ovalid = 0 in every state.
- Push into an empty DRAIN-state buffer is not a pass-through; it is visible after 1 cycle.
- Reset mid-stream discards all contents and served flags; no partial entry survives.

## Configuration
- STREAM_FORK_EAGER_EN defined: eager fork as described. Consumers may accept the head in different cycles.
- STREAM_FORK_EAGER_EN undefined: lazy fork with no served flags.
  - ovalid[i] = offering & nonempty & AND of oready[j] for j≠i.
  - Pop = offering & nonempty & AND of all oready.
  - This is identical to the existing ready-AND glue.

## Structure
- Package tytra_stream_pkg holds:
  - the clog2 helper;
  - the state encoding PRIME/RUN/DRAIN;
  - default DATAW = 34.
- Sub-module stream_fork_ctrl (NCONS, mode macro) owns served flags, ovalid generation and the pop decision.
- The top owns storage, pointers, count and the FSM.

## Test plan
- PRIME=22, DEPTH=23: push 22 entries (lane0 = 1..22) with oready held 0.
  - ovalid stays 0 through push 21.
  - Both ovalid bits rise after push 22; out lane0 = 1.
- Fill to 23 with oready = 0: iready = 0.
  - Assert both oready with ivalid held: one pop occurs, count = 22.
  - iready returns the next cycle; entry 24 lands at slot 0 (wrap).
- Eager mode with oready = 2'b01 for 3 cycles, then 2'b10:
  - Consumer 0 takes entry 1 once; ovalid[0] = 0 while waiting.
  - Pop occurs on consumer 1's handshake; count decrements by exactly 1.
- Lazy mode with the same stimulus: no handshake and no pop until oready = 2'b11; ovalid[i] tracks the other consumer's ready.
- PRIME=22, push 5 entries with the 5th carrying ilast:
  - DRAIN entered; all 5 are delivered with olast on the 5th.
  - State returns to PRIME; the next 3 pushes produce no ovalid.
- Assert rst low mid-drain with count = 7:
  - count, ovalid and iready go to 0 immediately.
  - After release, iready = 1 and the first new entry is the next head.

Source files
------------

// File: rtl/tytra_stream_pkg.sv
// Shared types and helpers for the tytra stream buffers (stream_fork_buffer and its fork control).
package tytra_stream_pkg;

  localparam int unsigned DefaultDataW = 34;

  typedef enum logic [1:0] {
    StPrime,
    StRun,
    StDrain
  } state_e;

  // Bits needed to index value distinct items; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    longint unsigned span;
    res  = 0;
    span = 1;
    while (span < longint'(value)) begin
      span = span << 1;
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_fork_ctrl.sv
// Output fork for stream_fork_buffer: per-consumer valid generation and the pop decision.
// STREAM_FORK_EAGER_EN selects the eager fork with served flags; otherwise the lazy ready-AND fork.
module stream_fork_ctrl #(
  parameter int unsigned NCONS = 2
) (
`ifdef STREAM_FORK_EAGER_EN
  input  logic             clk,
  input  logic             rst,
`endif
  input  logic             offer,
  input  logic             nonempty,
  input  logic [NCONS-1:0] oready,
  output logic [NCONS-1:0] ovalid,
  output logic             pop
);

  logic active;
  assign active = offer & nonempty;

`ifdef STREAM_FORK_EAGER_EN
  logic [NCONS-1:0] served_q, served_d, hs;

  // A consumer that already took the head stays quiet until the entry retires.
  always_comb begin
    ovalid   = {NCONS{active}} & ~served_q;
    hs       = ovalid & oready;
    pop      = active & (&(served_q | hs));
    served_d = pop ? '0 : (served_q | hs);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      served_q <= '0;
    end else begin
      served_q <= served_d;
    end
  end
`else
  always_comb begin
    ovalid = '0;
    for (int unsigned i = 0; i < NCONS; i++) begin
      ovalid[i] = active;
      for (int unsigned j = 0; j < NCONS; j++) begin
        if (j != i) begin
          ovalid[i] = ovalid[i] & oready[j];
        end
      end
    end
    pop = active & (&oready);
  end
`endif

endmodule

// File: rtl/stream_fork_buffer.sv
// Elastic NCH-lane stream buffer with priming threshold, drain-on-last and an NCONS-way fork.
// Fork style chosen by STREAM_FORK_EAGER_EN (see stream_fork_ctrl).
module stream_fork_buffer
  import tytra_stream_pkg::*;
#(
  parameter int unsigned DATAW = DefaultDataW,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 23,
  parameter int unsigned PRIME = 22,
  parameter int unsigned NCONS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NCH*DATAW-1:0]         in,
  input  logic                         ivalid,
  input  logic                         ilast,
  output logic                         iready,
  output logic [NCH*DATAW-1:0]         out,
  output logic [NCONS-1:0]             ovalid,
  input  logic [NCONS-1:0]             oready,
  output logic                         olast,
  output logic [clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned CW = clog2(DEPTH + 1);
  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned EW = NCH * DATAW;
  localparam logic [PW-1:0] LastSlot   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FullCount  = CW'(DEPTH);
  localparam logic [CW-1:0] PrimeCount = CW'(PRIME);

  logic [EW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] last_mem;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    lcnt_q, lcnt_d;  // stored entries carrying last
  state_e           state_q;
  logic             push, pop, head_last, offer, nonempty;

  assign iready    = rst & (count_q < FullCount);
  assign push      = ivalid & iready;
  assign nonempty  = count_q != '0;
  assign offer     = state_q != StPrime;
  assign out       = mem[rptr_q];
  assign head_last = last_mem[rptr_q];
  assign olast     = head_last & nonempty;
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    lcnt_d = lcnt_q;
    if ((push && ilast) && !(pop && head_last)) begin
      lcnt_d = lcnt_q + 1'b1;
    end else if (!(push && ilast) && (pop && head_last)) begin
      lcnt_d = lcnt_q - 1'b1;
    end
  end

  // Storage has no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q]      <= in;
      last_mem[wptr_q] <= ilast;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      lcnt_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= (wptr_q == LastSlot) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == LastSlot) ? '0 : rptr_q + 1'b1;
      end
      count_q <= count_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // Decisions use next-cycle occupancy so the push that meets the threshold opens the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StPrime;
    end else begin
      unique case (state_q)
        StPrime: begin
          if (lcnt_d != '0) begin
            state_q <= StDrain;
          end else if (count_d != '0 && count_d >= PrimeCount) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (lcnt_d != '0) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && head_last) begin
            state_q <= StPrime;
          end
        end
        default: state_q <= StPrime;
      endcase
    end
  end

  stream_fork_ctrl #(
    .NCONS (NCONS)
  ) u_fork (
`ifdef STREAM_FORK_EAGER_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .offer    (offer),
    .nonempty (nonempty),
    .oready   (oready),
    .ovalid   (ovalid),
    .pop      (pop)
  );

endmodule

// File: tb/tb_stream_fork_buffer.sv
// Directed scoreboard bench for stream_fork_buffer; expectations follow STREAM_FORK_EAGER_EN.
module tb_stream_fork_buffer;
  import tytra_stream_pkg::*;

  localparam int unsigned DATAW = 34;
  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 23;
  localparam int unsigned PRIME = 22;
  localparam int unsigned NCONS = 2;
  localparam int unsigned CW    = clog2(DEPTH + 1);

`ifdef STREAM_FORK_EAGER_EN
  localparam logic [1:0] Peek      = 2'b00;
  localparam logic [1:0] OfferPeek = 2'b11;
`else
  // Lazy fork shows valid only through the other consumer's ready; 01 never pops.
  localparam logic [1:0] Peek      = 2'b01;
  localparam logic [1:0] OfferPeek = 2'b10;
`endif

  typedef struct packed {
    logic             last;
    logic [DATAW-1:0] l1;
    logic [DATAW-1:0] l0;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH*DATAW-1:0] in;
  logic                 ivalid, ilast, iready, olast;
  logic [NCH*DATAW-1:0] out;
  logic [NCONS-1:0]     ovalid, oready;
  logic [CW-1:0]        count;

  exp_t        sb[$];
  logic [1:0]  served;
  int unsigned ntests = 0;
  int unsigned nfail  = 0;
  int unsigned npop   = 0;

  always #5 clk = ~clk;

  stream_fork_buffer #(
    .DATAW (DATAW),
    .NCH   (NCH),
    .DEPTH (DEPTH),
    .PRIME (PRIME),
    .NCONS (NCONS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .ivalid (ivalid),
    .ilast  (ilast),
    .iready (iready),
    .out    (out),
    .ovalid (ovalid),
    .oready (oready),
    .olast  (olast),
    .count  (count)
  );

  function automatic logic [NCH*DATAW-1:0] make_entry(input int unsigned v);
    return {DATAW'(v * 3 + 7), DATAW'(v)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Record pushes/handshakes for the current cycle, then advance one clock.
  task automatic tick();
    exp_t e;
    #1;
    if (ivalid && iready) begin
      e.last = ilast;
      e.l1   = in[2*DATAW-1:DATAW];
      e.l0   = in[DATAW-1:0];
      sb.push_back(e);
    end
    for (int i = 0; i < int'(NCONS); i++) begin
      if (ovalid[i] && oready[i]) begin
        if (sb.size() == 0) begin
          check("handshake_on_empty_model", 1, 0);
        end else begin
          check("out_data", out, {sb[0].l1, sb[0].l0});
          check("out_last", olast, sb[0].last);
        end
        served[i] = 1'b1;
      end
    end
    if (&served) begin
      if (sb.size() != 0) sb.delete(0);
      served = '0;
      npop++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b0;
    in     = '0;
    ivalid = 1'b0;
    ilast  = 1'b0;
    oready = '0;
    served = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", count, 0);
    check("reset_iready", iready, 0);
    check("reset_ovalid", ovalid, 0);
    check("reset_olast", olast, 0);
    rst = 1'b1;
    #1;
    check("iready_after_reset", iready, 1);

    // Prime to 22 entries.
    oready = Peek;
    for (int unsigned v = 1; v <= 22; v++) begin
      in     = make_entry(v);
      ivalid = 1'b1;
      tick();
      if (v < 22) check("prime_ovalid_low", ovalid, 0);
    end
    ivalid = 1'b0;
    #1;
    check("primed_ovalid", ovalid, OfferPeek);
    check("primed_head_lane0", out[DATAW-1:0], 1);
    check("primed_count", count, 22);

    // Fill to full, then one pop with ivalid held.
    in     = make_entry(23);
    ivalid = 1'b1;
    tick();
    check("full_count", count, 23);
    check("full_iready", iready, 0);
    in     = make_entry(24);
    oready = 2'b11;
    tick();
    check("pop_when_full_count", count, 22);
    check("iready_reopens", iready, 1);
    oready = Peek;
    tick();
    ivalid = 1'b0;
    check("wrap_push_count", count, 23);

    // Consumers ready in different cycles.
    oready = 2'b01;
    tick();
    check("fork_ovalid_c0_wait", ovalid, 2'b10);
    tick();
    tick();
    check("fork_no_pop_count", count, 23);
    check("fork_ovalid_hold", ovalid, 2'b10);
    oready = 2'b10;
`ifdef STREAM_FORK_EAGER_EN
    tick();
    check("fork_pop_count", count, 22);
`else
    #1;
    check("lazy_ovalid_other_ready", ovalid, 2'b01);
    tick();
    check("lazy_no_pop_count", count, 23);
    oready = 2'b11;
    tick();
    check("lazy_pop_count", count, 22);
`endif

    // Drain remaining entries in order (3..24, including the wrapped slot).
    oready = 2'b11;
    for (int k = 0; k < 40 && count != 0; k++) tick();
    check("drain_count", count, 0);
    check("drain_ovalid", ovalid, 0);
    check("drain_scoreboard_empty", sb.size(), 0);
    check("pop_total", npop, 24);

    rst = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b1;
    sb.delete();
    served = '0;

    // Short stream terminated by ilast forces drain without reaching PRIME.
    oready = Peek;
    for (int unsigned v = 101; v <= 105; v++) begin
      in     = make_entry(v);
      ilast  = (v == 105);
      ivalid = 1'b1;
      tick();
      if (v < 105) check("last_prime_ovalid_low", ovalid, 0);
    end
    ivalid = 1'b0;
    ilast  = 1'b0;
    #1;
    check("drain_entered_ovalid", ovalid, OfferPeek);
    check("drain_head_not_last", olast, 0);
    oready = 2'b11;
    for (int k = 0; k < 20 && count != 0; k++) tick();
    check("last_drain_count", count, 0);
    check("last_drain_scoreboard", sb.size(), 0);

    oready = Peek;
    for (int unsigned v = 201; v <= 203; v++) begin
      in     = make_entry(v);
      ivalid = 1'b1;
      tick();
      check("reprime_ovalid_low", ovalid, 0);
    end
    check("reprime_count", count, 3);

    // Mid-drain asynchronous reset.
    for (int unsigned v = 204; v <= 207; v++) begin
      in     = make_entry(v);
      ilast  = (v == 207);
      ivalid = 1'b1;
      tick();
    end
    ivalid = 1'b0;
    ilast  = 1'b0;
    check("middrain_count", count, 7);
    check("middrain_ovalid", ovalid, OfferPeek);
    rst = 1'b0;
    #1;
    check("async_reset_count", count, 0);
    check("async_reset_ovalid", ovalid, 0);
    check("async_reset_iready", iready, 0);
    sb.delete();
    served = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("post_reset_iready", iready, 1);

    in     = make_entry(301);
    ilast  = 1'b1;
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
    ilast  = 1'b0;
    check("new_head_ovalid", ovalid, OfferPeek);
    check("new_head_lane0", out[DATAW-1:0], 301);
    check("new_head_olast", olast, 1);
    oready = 2'b11;
    tick();
    check("new_head_popped", count, 0);
    check("final_scoreboard", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
